// File: rtl/bt656_pkg.sv
// Shared constants, region type and word helpers for the BT.656 transmit path.
package bt656_pkg;

    // Default raster geometry (525-line, 1716-word-per-line 10-bit stream).
    localparam int DEF_WORDS_PER_LINE  = 1716;
    localparam int DEF_BLANK_WORDS     = 268;
    localparam int DEF_LINES_PER_FRAME = 525;

    // Timing reference preamble words.
    localparam logic [9:0] TRS_PREAMBLE0 = 10'h3FF;
    localparam logic [9:0] TRS_PREAMBLE1 = 10'h000;

    // Black level: chroma and luma halves of the Cb/Y/Cr/Y sequence.
    localparam logic [9:0] BLANK_C = 10'h200;
    localparam logic [9:0] BLANK_Y = 10'h040;

    // Legal active-video range; codes outside it are reserved for TRS.
    localparam logic [9:0] PIX_MIN = 10'h004;
    localparam logic [9:0] PIX_MAX = 10'h3FB;

    // Position of the current word within the line.
    typedef enum logic [1:0] {
        REG_EAV    = 2'd0,
        REG_HBLANK = 2'd1,
        REG_SAV    = 2'd2,
        REG_ACTIVE = 2'd3
    } region_t;

    // Protected XY word of an EAV/SAV.
    function automatic logic [9:0] bt656_xy(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
    endfunction

    // Keep active samples out of the 0x000-0x003 / 0x3FC-0x3FF TRS ranges.
    function automatic logic [9:0] clamp_pixel(input logic [9:0] px);
        if (px < PIX_MIN) begin
            return PIX_MIN;
        end else if (px > PIX_MAX) begin
            return PIX_MAX;
        end
        return px;
    endfunction

endpackage

// File: rtl/bt656_sync_generator_if.sv
// Ready/valid pixel handshake between an upstream pixel source and the generator.
interface bt656_sync_generator_if;

    logic [9:0] pixel_in;
    logic       pixel_in_valid;
    logic       pixel_ready;

    // Pixel source side.
    modport master (
        output pixel_in,
        output pixel_in_valid,
        input  pixel_ready
    );

    // Generator side.
    modport slave (
        input  pixel_in,
        input  pixel_in_valid,
        output pixel_ready
    );

endinterface

// File: rtl/bt656_line_timer.sv
// Horizontal word counter and line counter, with region and H/V/F decode
// for the counter state currently held.
module bt656_line_timer
    import bt656_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int BLANK_WORDS     = DEF_BLANK_WORDS,    // must be even
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    output region_t    region_o,
    output logic [1:0] trs_pos_o,     // word index inside EAV/SAV
    output logic       odd_o,         // odd offset from word 4 -> luma blank
    output logic       h_o,
    output logic       v_o,
    output logic       f_o,
    output logic [9:0] line_o,
    output logic       frame_first_o  // word 0 of line 1
);

    localparam int HW        = $clog2(WORDS_PER_LINE);
    localparam int SAV_START = 4 + BLANK_WORDS;
    localparam int ACT_START = SAV_START + 4;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [9:0]    line_q,  line_d;
    logic [HW-1:0] sav_off;

    // Next counter state: h_cnt wraps at end of line, line wraps after the last line.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        h_cnt_d = h_cnt_q + HW'(1);
        line_d  = line_q;
        if (h_cnt_q == HW'(WORDS_PER_LINE - 1)) begin
            h_cnt_d = '0;
            line_d  = (line_q == 10'(LINES_PER_FRAME)) ? 10'd1 : line_q + 10'd1;
        end
    end

    // Counter registers; advance only on enabled cycles, restart at line 1 word 0.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            h_cnt_q <= '0;
            line_q  <= 10'd1;
        end else if (enable_i) begin
            h_cnt_q <= h_cnt_d;
            line_q  <= line_d;
        end
    end

    // Region decode along the line.
    always_comb begin
        region_o = REG_ACTIVE;
        if (h_cnt_q < HW'(4)) begin
            region_o = REG_EAV;
        end else if (h_cnt_q < HW'(SAV_START)) begin
            region_o = REG_HBLANK;
        end else if (h_cnt_q < HW'(ACT_START)) begin
            region_o = REG_SAV;
        end
    end

    // Word position inside the TRS; SAV is re-based on its own first word.
    assign sav_off   = h_cnt_q - HW'(SAV_START);
    assign trs_pos_o = (region_o == REG_SAV) ? sav_off[1:0] : h_cnt_q[1:0];

    // Word 4 is even, so blanking parity is simply the counter LSB.
    assign odd_o = h_cnt_q[0];

    // Line flags: V covers lines 1-19 and 264-282; field 2 spans 1-3 and 266-525.
    always_comb begin
        v_o = ((line_q >= 10'd1) && (line_q <= 10'd19)) ||
              ((line_q >= 10'd264) && (line_q <= 10'd282));
        f_o = (line_q <= 10'd3) || (line_q >= 10'd266);
    end

    assign h_o           = (region_o != REG_ACTIVE);
    assign line_o        = line_q;
    assign frame_first_o = (h_cnt_q == '0) && (line_q == 10'd1);

endmodule

// File: rtl/bt656_sync_generator.sv
// BT.656 10-bit stream generator: TRS insertion, black fill, and
// ready/valid pull of active-video samples from an upstream source.
module bt656_sync_generator
    import bt656_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int BLANK_WORDS     = DEF_BLANK_WORDS,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    bt656_sync_generator_if.slave        pix,
    output logic [9:0]                   bt656,
    output logic                         H,
    output logic                         V,
    output logic                         F,
    output logic [9:0]                   line_number,
    output logic                         frame_start,
    output logic                         underflow
);

    region_t    region;
    logic [1:0] trs_pos;
    logic       odd;
    logic       h_flag, v_flag, f_flag;
    logic [9:0] line;
    logic       frame_first;

    logic [9:0] blank_word;
    logic       ready;
    logic [9:0] word_d;
    logic       underflow_d;

    logic [9:0] bt656_q;
    logic       h_q, v_q, f_q;
    logic [9:0] line_number_q;
    logic       frame_start_q;
    logic       underflow_q;

    bt656_line_timer #(
        .WORDS_PER_LINE  (WORDS_PER_LINE),
        .BLANK_WORDS     (BLANK_WORDS),
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable),
        .region_o      (region),
        .trs_pos_o     (trs_pos),
        .odd_o         (odd),
        .h_o           (h_flag),
        .v_o           (v_flag),
        .f_o           (f_flag),
        .line_o        (line),
        .frame_first_o (frame_first)
    );

    // Samples are requested only in the active region of a picture line.
    assign ready           = enable && (region == REG_ACTIVE) && !v_flag;
    assign pix.pixel_ready = ready;

    assign blank_word = odd ? BLANK_Y : BLANK_C;

    // Word for the current counter state, and the underflow it may raise.
    always_comb begin
        word_d      = blank_word;
        underflow_d = underflow_q | (ready & ~pix.pixel_in_valid);
        unique case (region)
            REG_EAV, REG_SAV: begin
                unique case (trs_pos)
                    2'd0:       word_d = TRS_PREAMBLE0;
                    2'd1, 2'd2: word_d = TRS_PREAMBLE1;
                    default:    word_d = bt656_xy(f_flag, v_flag, region == REG_EAV);
                endcase
            end
            REG_ACTIVE: begin
                // A missing sample falls back to black for this offset.
                if (ready && pix.pixel_in_valid) begin
                    word_d = clamp_pixel(pix.pixel_in);
                end
            end
            default: word_d = blank_word;
        endcase
    end

    // Output registers: word and its flags land together one cycle after the counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bt656_q       <= 10'h000;
            h_q           <= 1'b0;
            v_q           <= 1'b0;
            f_q           <= 1'b0;
            line_number_q <= 10'd1;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else if (enable) begin
            bt656_q       <= word_d;
            h_q           <= h_flag;
            v_q           <= v_flag;
            f_q           <= f_flag;
            line_number_q <= line;
            frame_start_q <= frame_first;
            underflow_q   <= underflow_d;
        end
    end

    assign bt656       = bt656_q;
    assign H           = h_q;
    assign V           = v_q;
    assign F           = f_q;
    assign line_number = line_number_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule
